// File: rtl/roic_pkg.sv
// Shared types and default geometry for the ROIC receive path.
// Pixel struct fields are sized for the default geometry; smaller ROWS/COLS/PIX_W fit in the low bits.
package roic_pkg;
  localparam int DEF_COLS  = 640;
  localparam int DEF_ROWS  = 512;
  localparam int DEF_PIX_W = 14;
  localparam int ROW_W     = $clog2(DEF_ROWS);
  localparam int COL_W     = $clog2(DEF_COLS);

  typedef enum logic {WAIT_SOF, IN_FRAME} rx_state_t;

  typedef struct packed {
    logic [DEF_PIX_W-1:0] data;
    logic [ROW_W-1:0]     row;
    logic [COL_W-1:0]     col;
    logic                 sof;
    logic                 eol;
    logic                 eof;
  } pixel_t;
endpackage

// File: rtl/roic_onehot_decode.sv
// One-hot to binary index; 'one' flags exactly one bit set.
module roic_onehot_decode #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         one
);
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++)
      if (vec[i]) idx = idx | W'(i);
  end

  // Nonzero and clearing the lowest set bit leaves nothing.
  assign one = (vec != '0) && ((vec & (vec - N'(1))) == '0);
endmodule

// File: rtl/roic_pixel_collector.sv
// ROIC receive end: decodes one-hot row/col scan enables, checks raster order, tags SOF/EOL/EOF
// and streams pixels through a FWFT FIFO. Optional error counter: ROIC_RX_ERR_CNT_EN.
module roic_pixel_collector
  import roic_pkg::*;
#(
  parameter int COLS       = DEF_COLS,
  parameter int ROWS       = DEF_ROWS,
  parameter int PIX_W      = DEF_PIX_W,
  parameter int FIFO_DEPTH = 8,
  localparam int RW = $clog2(ROWS),
  localparam int CW = $clog2(COLS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ROWS-1:0]  row_en,
  input  logic [COLS-1:0]  col_en,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [PIX_W-1:0] m_data,
  output logic [RW-1:0]    m_row,
  output logic [CW-1:0]    m_col,
  output logic             m_sof,
  output logic             m_eol,
  output logic             m_eof,
  output logic             onehot_err,
  output logic             seq_err,
  output logic             overflow,
  output logic [15:0]      frame_count
`ifdef ROIC_RX_ERR_CNT_EN
  ,
  input  logic             err_clr,
  output logic [15:0]      err_count
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = PW + 1;

  logic [RW-1:0] row_idx, s1_row, exp_row, exp_row_nxt;
  logic [CW-1:0] col_idx, s1_col, exp_col, exp_col_nxt;
  logic          row_one, col_one, s1_vld;
  logic [PIX_W-1:0] s1_data;
  rx_state_t     state, state_nxt;

  roic_onehot_decode #(.N(ROWS)) u_row_dec (.vec(row_en), .idx(row_idx), .one(row_one));
  roic_onehot_decode #(.N(COLS)) u_col_dec (.vec(col_en), .idx(col_idx), .one(col_one));

  // Stage 1: register decoded position; bad enables are dropped here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld     <= 1'b0;
      s1_row     <= '0;
      s1_col     <= '0;
      s1_data    <= '0;
      onehot_err <= 1'b0;
    end else begin
      s1_vld     <= pix_valid & row_one & col_one;
      onehot_err <= pix_valid & ~(row_one & col_one);
      s1_row     <= row_idx;
      s1_col     <= col_idx;
      s1_data    <= pix_data;
    end
  end

  logic at_origin, at_eol, at_eof, mismatch, accept, seq_err_d;
  assign at_origin = (s1_row == '0) && (s1_col == '0);
  assign at_eol    = (s1_col == CW'(COLS-1));
  assign at_eof    = at_eol && (s1_row == RW'(ROWS-1));
  assign mismatch  = (s1_row != exp_row) || (s1_col != exp_col);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= WAIT_SOF;
      exp_row <= '0;
      exp_col <= '0;
    end else begin
      state   <= state_nxt;
      exp_row <= exp_row_nxt;
      exp_col <= exp_col_nxt;
    end
  end

  // Stage 2: order check and resync; the FSM advances even if the FIFO drops the pixel.
  always_comb begin
    state_nxt   = state;
    exp_row_nxt = exp_row;
    exp_col_nxt = exp_col;
    accept      = 1'b0;
    seq_err_d   = 1'b0;
    if (s1_vld) begin
      case (state)
        WAIT_SOF: accept = at_origin;
        IN_FRAME: begin
          accept    = 1'b1;
          seq_err_d = mismatch;
        end
        default: accept = 1'b0;
      endcase
    end
    if (accept) begin
      if (at_eof) begin
        state_nxt   = WAIT_SOF;
        exp_row_nxt = '0;
        exp_col_nxt = '0;
      end else begin
        state_nxt = IN_FRAME;
        if (at_eol) begin
          exp_row_nxt = s1_row + RW'(1);
          exp_col_nxt = '0;
        end else begin
          exp_row_nxt = s1_row;
          exp_col_nxt = s1_col + CW'(1);
        end
      end
    end
  end

  // Output FIFO, first-word fall-through.
  pixel_t        mem [FIFO_DEPTH];
  pixel_t        wr_pix, rd_pix;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [NW-1:0] count;
  logic          full, wr_en, rd_en, drop;

  assign full  = (count == NW'(FIFO_DEPTH));
  assign wr_en = accept & ~full;
  assign drop  = accept & full;
  assign rd_en = m_valid & m_ready;

  always_comb begin
    wr_pix                = '0;
    wr_pix.data[PIX_W-1:0] = s1_data;
    wr_pix.row[RW-1:0]    = s1_row;
    wr_pix.col[CW-1:0]    = s1_col;
    wr_pix.sof            = at_origin;
    wr_pix.eol            = at_eol;
    wr_pix.eof            = at_eof;
  end

  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= wr_pix;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_pix  = mem[rd_ptr];
  assign m_valid = (count != '0);
  assign m_data  = m_valid ? rd_pix.data[PIX_W-1:0] : '0;
  assign m_row   = m_valid ? rd_pix.row[RW-1:0] : '0;
  assign m_col   = m_valid ? rd_pix.col[CW-1:0] : '0;
  assign m_sof   = m_valid & rd_pix.sof;
  assign m_eol   = m_valid & rd_pix.eol;
  assign m_eof   = m_valid & rd_pix.eof;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_err     <= 1'b0;
      overflow    <= 1'b0;
      frame_count <= '0;
    end else begin
      seq_err  <= seq_err_d;
      overflow <= overflow | drop;
      if (wr_en && at_eof) frame_count <= frame_count + 16'd1;
    end
  end

`ifdef ROIC_RX_ERR_CNT_EN
  logic        drop_q;
  logic [1:0]  err_ev;
  logic [16:0] err_sum;
  assign err_ev  = {1'b0, onehot_err} + {1'b0, seq_err} + {1'b0, drop_q};
  assign err_sum = {1'b0, err_count} + {15'd0, err_ev};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q    <= 1'b0;
      err_count <= '0;
    end else begin
      drop_q <= drop;
      if (err_clr)         err_count <= '0;
      else if (err_sum[16]) err_count <= 16'hFFFF;
      else                 err_count <= err_sum[15:0];
    end
  end
`endif
endmodule

// File: tb/tb_roic_pixel_collector.sv
// Scoreboard bench for roic_pixel_collector on a reduced 4x8 raster.
module tb_roic_pixel_collector;
  localparam int ROWS = 4, COLS = 8, PIX_W = 14, DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  logic [ROWS-1:0] row_en;
  logic [COLS-1:0] col_en;
  logic pix_valid;
  logic [PIX_W-1:0] pix_data;
  logic m_valid, m_ready;
  logic [PIX_W-1:0] m_data;
  logic [1:0] m_row;
  logic [2:0] m_col;
  logic m_sof, m_eol, m_eof, onehot_err, seq_err, overflow;
  logic [15:0] frame_count;
`ifdef ROIC_RX_ERR_CNT_EN
  logic err_clr;
  logic [15:0] err_count;
`endif

  roic_pixel_collector #(.COLS(COLS), .ROWS(ROWS), .PIX_W(PIX_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .row_en(row_en), .col_en(col_en), .pix_valid(pix_valid),
    .pix_data(pix_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_row(m_row), .m_col(m_col), .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof),
    .onehot_err(onehot_err), .seq_err(seq_err), .overflow(overflow),
    .frame_count(frame_count)
`ifdef ROIC_RX_ERR_CNT_EN
    , .err_clr(err_clr), .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  int passes = 0, total = 0, oh_cnt = 0, seq_cnt = 0;
  logic [21:0] sb[$];

  function automatic logic [21:0] pk(int d, int r, int c, bit s, bit l, bit f);
    return {14'(d), 2'(r), 3'(c), s, l, f};
  endfunction

  task automatic chk(string n, longint act, longint exp);
    total++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask

  // Monitor: pops on every accepted transfer and counts error pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (onehot_err) oh_cnt++;
      if (seq_err) seq_cnt++;
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_pixel: got %0h with nothing expected",
                   {m_data, m_row, m_col, m_sof, m_eol, m_eof});
        end else chk("pixel", {m_data, m_row, m_col, m_sof, m_eol, m_eof}, sb.pop_front());
      end
    end
  end

  task automatic send_raw(logic [ROWS-1:0] re, logic [COLS-1:0] ce, int d);
    row_en = re; col_en = ce; pix_valid = 1'b1; pix_data = 14'(d);
    @(posedge clk); #1;
    pix_valid = 1'b0; row_en = '0; col_en = '0;
  endtask

  task automatic send(int r, int c, int d);
    logic [ROWS-1:0] re;
    logic [COLS-1:0] ce;
    re = '0; ce = '0; re[r] = 1'b1; ce[c] = 1'b1;
    send_raw(re, ce, d);
  endtask

  task automatic drain(string n);
    int k = 0;
    repeat (3) @(posedge clk);
    while ((sb.size() != 0 || m_valid) && k < 200) begin
      @(posedge clk); k++;
    end
    #1;
    chk(n, sb.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; row_en = '0; col_en = '0; pix_valid = 1'b0; pix_data = '0; m_ready = 1'b1;
`ifdef ROIC_RX_ERR_CNT_EN
    err_clr = 1'b0;
`endif
    repeat (2) @(posedge clk); #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_onehot_err", onehot_err, 0);
    chk("rst_seq_err", seq_err, 0);
    rst = 1'b0;

    // Full raster with m_ready held high.
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        sb.push_back(pk(r*8 + c + 100, r, c, (r == 0 && c == 0), c == 7, (r == 3 && c == 7)));
        send(r, c, r*8 + c + 100);
      end
    drain("raster_drain");
    chk("raster_frame_count", frame_count, 1);
    chk("raster_seq_cnt", seq_cnt, 0);

    // Waiting for SOF: non-origin pixel silently dropped.
    send(1, 2, 5);
    drain("wait_sof_drop");
    chk("wait_sof_no_seq", seq_cnt, 0);

    // Bad enable patterns; idle all-zero enables are not errors.
    send_raw(4'b0001, 8'b0000_0000, 1);
    send_raw(4'b0001, 8'b0000_0110, 2);
    repeat (3) @(posedge clk); #1;
    chk("onehot_cnt", oh_cnt, 2);
    drain("onehot_no_write");

    // Skip inside a frame, then an early (0,0).
    for (int c = 0; c < COLS; c++) begin
      sb.push_back(pk(200 + c, 0, c, c == 0, c == 7, 0));
      send(0, c, 200 + c);
    end
    sb.push_back(pk(210, 1, 0, 0, 0, 0)); send(1, 0, 210);
    sb.push_back(pk(211, 1, 1, 0, 0, 0)); send(1, 1, 211);
    sb.push_back(pk(213, 1, 3, 0, 0, 0)); send(1, 3, 213);
    sb.push_back(pk(214, 1, 4, 0, 0, 0)); send(1, 4, 214);
    @(posedge clk); #1;
    chk("seq_skip_once", seq_cnt, 1);
    sb.push_back(pk(300, 0, 0, 1, 0, 0)); send(0, 0, 300);
    sb.push_back(pk(301, 0, 1, 0, 0, 0)); send(0, 1, 301);
    drain("seq_drain");
    chk("seq_resof", seq_cnt, 2);

    // Overflow: 9 pixels into an 8-deep FIFO with m_ready low.
    m_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      int r, c;
      r = (i < 6) ? 0 : 1;
      c = (i < 6) ? i + 2 : i - 6;
      if (i < 8) sb.push_back(pk(i, r, c, 0, (r == 0 && c == 7), 0));
      send(r, c, i);
    end
    repeat (4) @(posedge clk); #1;
    chk("ovf_set", overflow, 1);
    chk("ovf_m_valid", m_valid, 1);
    chk("ovf_head_held", m_data, 0);
    m_ready = 1'b1;
    drain("ovf_drain");
    chk("ovf_sticky", overflow, 1);
    chk("ovf_seq_none", seq_cnt, 2);

    // Reset mid-frame with a pixel waiting in the FIFO.
    m_ready = 1'b0;
    send(1, 3, 50);
    repeat (3) @(posedge clk); #1;
    chk("pre_rst_valid", m_valid, 1);
    rst = 1'b1;
    sb.delete();
    #1;
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_frame_count", frame_count, 0);
    @(posedge clk); #1;
    rst = 1'b0; m_ready = 1'b1;
    sb.push_back(pk(77, 0, 0, 1, 0, 0)); send(0, 0, 77);
    sb.push_back(pk(78, 0, 2, 0, 0, 0)); send(0, 2, 78);
    send_raw(4'b0000, 8'b0000_0001, 3);
    send_raw(4'b0011, 8'b0000_0001, 4);
    drain("restart_drain");
    chk("restart_seq_cnt", seq_cnt, 3);
    chk("restart_oh_cnt", oh_cnt, 4);
`ifdef ROIC_RX_ERR_CNT_EN
    chk("err_count", err_count, 3);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("err_count_clr", err_count, 0);
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
